sdram_rr_arbiter: RTL and testbench
===================================

Name: sdram_rr_arbiter

Overview:
- Two-master Avalon-MM arbiter that shares the single SDRAM controller slave port between the Nios II data path and one custom fabric master.
- Sits in the FPGA fabric between the two masters and the SoC's SDRAM slave.
- Round-robin grant with parking; honours slave waitrequest; tracks outstanding pipelined reads so each readdatavalid is routed back to the master that issued the read.

Parameters:
- ADDR_W, 25, word address width toward the SDRAM slave.
- DATA_W, 16, data width (matches the 16-bit DRAM_DQ); BE_W = DATA_W/8 is derived.
- MAX_PEND, 4, maximum outstanding reads; power of two, at least 2.

Ports:
- clk  in  1  single clock; every register is clocked on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- mX_address  in  ADDR_W  master X address (X = 0,1; the same set of ports exists for each master).
- mX_read, mX_write  in  1  master X command strobes.
- mX_writedata  in  DATA_W  master X write data.
- mX_byteenable  in  BE_W  master X byte enables.
- mX_waitrequest  out  1  stall to master X.
- mX_readdata  out  DATA_W  read data returned to master X.
- mX_readdatavalid  out  1  read data valid for master X.
- s_address  out  ADDR_W  address toward the SDRAM slave.
- s_read, s_write  out  1  command strobes toward the slave.
- s_writedata  out  DATA_W  write data toward the slave.
- s_byteenable  out  BE_W  byte enables toward the slave.
- s_waitrequest  in  1  slave stall.
- s_readdata  in  DATA_W  slave read data.
- s_readdatavalid  in  1  slave read data valid.
- pend_cnt  out  $clog2(MAX_PEND)+1  number of outstanding reads.
- proto_err  out  1  sticky protocol-error flag.

Behaviour:
- State machine with states IDLE, OWN0, OWN1. Reset enters IDLE.
- Reset values: mX_waitrequest=1, mX_readdatavalid=0, all s_* command outputs=0, pend_cnt=0, proto_err=0. A reset mid-transfer discards the tag FIFO.
- reqX = mX_read | mX_write. accX = (state==OWNX) & reqX & !s_waitrequest & !blk.
- blk = mX_read & (pend_cnt==MAX_PEND). A full FIFO blocks reads only; writes proceed.
- IDLE: if req0, go to OWN0 (m0 wins a tie out of reset); else if req1, go to OWN1; else stay in IDLE.
- OWNX, reqX high but not accepted: stay in OWNX. Signals are held stable per Avalon; no preemption.
- OWNX, accepted or reqX low: go to OWN(other) if the other master requests, else stay parked in OWNX.
- Consequences: a sole requester gets back-to-back transfers; with both requesting, grants alternate every accepted transfer.
- Slave muxing (combinational from the state register):
  - In OWNX, s_address, s_writedata and s_byteenable come from master X.
  - s_read = mX_read & !blk; s_write = mX_write.
  - In IDLE, all s_* outputs are 0.
- mX_waitrequest = !((state==OWNX) & !s_waitrequest & !blk). It is 1 in IDLE and for the non-owner.
- Every master sees at least one cycle of waitrequest after raising its request from IDLE; grant latency is 1 cycle.
- Tag FIFO:
  - Push the owner ID when s_read & !s_waitrequest.
  - Pop the head when s_readdatavalid.
  - mX_readdatavalid = s_readdatavalid & (head==X), combinational, zero added latency.
  - mX_readdata = s_readdata to both masters.
  - Simultaneous push and pop leaves pend_cnt unchanged. A push while full is impossible by construction.
- Errors (each sets proto_err until reset):
  - Owner asserts read and write together: the read is forwarded, the write is suppressed, proto_err is set.
  - s_readdatavalid with an empty FIFO: data is dropped, no master valid is asserted, proto_err is set.
- Pointer arithmetic: FIFO pointers wrap modulo MAX_PEND.

Decomposition:
- Package sdram_arb_pkg holds: typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_t; typedef logic owner_t; constant M0 = 1'b0; constant M1 = 1'b1.
- One sub-module, arb_tag_fifo: depth MAX_PEND, 1-bit wide, ports push, pop, din, head, count, empty, full.
- The top module holds the FSM and the muxes.

Test Plan:
- Reset then sole master: m0 writes addr 0x0000010 data 0xBEEF, s_waitrequest=0 -> state reaches OWN0 after 1 cycle; s_write high 1 cycle carrying 0x10/0xBEEF; m0_waitrequest low that cycle.
- Contention: m0 and m1 both issue 4 reads continuously, slave never stalls -> s_read owners alternate 0,1,0,1,...; pend_cnt never exceeds 4.
- Read return routing: m0 reads A, m1 reads B; slave returns 0x1111 then 0x2222 after 3 cycles -> m0_readdatavalid on 0x1111 only, m1_readdatavalid on 0x2222 only.
- FIFO full: 4 reads outstanding with no readdatavalid -> 5th read held with waitrequest=1 and s_read=0; a concurrent write from the owner is still forwarded; one readdatavalid releases the read next cycle.
- Stall hold: s_waitrequest high for 5 cycles during an m1 write while m0 requests -> state stays OWN1 and s_* stable; switches to OWN0 the cycle after acceptance.
- Errors and reset: spurious s_readdatavalid with pend_cnt=0 -> no master valid, proto_err=1; assert reset_n low with 2 reads pending -> pend_cnt=0, proto_err=0, all waitrequests 1 immediately.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: shared types for the two-master SDRAM round-robin arbiter.
package sdram_arb_pkg;

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_t;

    typedef logic owner_t;

    localparam owner_t M0 = 1'b0;
    localparam owner_t M1 = 1'b1;

endpackage

// File: rtl/arb_tag_fifo.sv
// arb_tag_fifo: tracks which master issued each outstanding read, in issue order.
module arb_tag_fifo
    import sdram_arb_pkg::*;
#(
    parameter int MAX_PEND = 4,
    localparam int PW = $clog2(MAX_PEND)
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        push,
    input  logic        pop,
    input  owner_t      din,
    output owner_t      head,
    output logic [PW:0] count,
    output logic        empty,
    output logic        full
);

    localparam logic [PW:0] FULL_CNT = (PW + 1)'(MAX_PEND);

    owner_t        r_mem [MAX_PEND];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign empty  = (r_count == '0);
    assign full   = (r_count == FULL_CNT);
    assign count  = r_count;
    assign head   = r_mem[r_rd_ptr];
    assign w_push = push & !full;
    assign w_pop  = pop & !empty;

    // Pointers wrap naturally because MAX_PEND is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= r_count + (PW + 1)'(w_push) - (PW + 1)'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= din;
    end

endmodule

// File: rtl/sdram_rr_arbiter.sv
// sdram_rr_arbiter: two-master Avalon-MM round-robin arbiter with parking in front of
// the SDRAM slave; routes pipelined read data back to the issuing master.
module sdram_rr_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W   = 25,
    parameter int DATA_W   = 16,
    parameter int MAX_PEND = 4,
    localparam int BE_W    = DATA_W / 8,
    localparam int CW      = $clog2(MAX_PEND) + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    input  logic [BE_W-1:0]   m0_byteenable,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    input  logic [BE_W-1:0]   m1_byteenable,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] s_address,
    output logic              s_read,
    output logic              s_write,
    output logic [DATA_W-1:0] s_writedata,
    output logic [BE_W-1:0]   s_byteenable,
    input  logic              s_waitrequest,
    input  logic [DATA_W-1:0] s_readdata,
    input  logic              s_readdatavalid,
    output logic [CW-1:0]     pend_cnt,
    output logic              proto_err
);

    arb_state_t r_state;
    arb_state_t w_next;
    logic       r_proto_err;
    logic       w_own0;
    logic       w_own1;
    logic       w_req0;
    logic       w_req1;
    logic       w_blk0;
    logic       w_blk1;
    logic       w_acc0;
    logic       w_acc1;
    logic       w_push;
    logic       w_empty;
    logic       w_full;
    logic       w_err;
    owner_t     w_owner;
    owner_t     w_head;

    assign w_own0  = (r_state == OWN0);
    assign w_own1  = (r_state == OWN1);
    assign w_req0  = m0_read | m0_write;
    assign w_req1  = m1_read | m1_write;
    // A full tag FIFO stalls reads only; writes never need a tag.
    assign w_blk0  = m0_read & w_full;
    assign w_blk1  = m1_read & w_full;
    assign w_acc0  = w_own0 & w_req0 & !s_waitrequest & !w_blk0;
    assign w_acc1  = w_own1 & w_req1 & !s_waitrequest & !w_blk1;
    assign w_owner = w_own1 ? M1 : M0;
    assign w_push  = s_read & !s_waitrequest;
    assign w_err   = (w_own0 & m0_read & m0_write) | (w_own1 & m1_read & m1_write)
                   | (s_readdatavalid & w_empty);
    assign proto_err = r_proto_err;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else r_state <= w_next;
    end

    // The owner keeps the port until its transfer is accepted, then yields to a waiting peer.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    w_next = w_req0 ? OWN0 : w_req1 ? OWN1 : IDLE;
            OWN0:    w_next = (w_req0 & !w_acc0) ? OWN0 : w_req1 ? OWN1 : OWN0;
            OWN1:    w_next = (w_req1 & !w_acc1) ? OWN1 : w_req0 ? OWN0 : OWN1;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        s_address        = w_own1 ? m1_address : w_own0 ? m0_address : '0;
        s_writedata      = w_own1 ? m1_writedata : w_own0 ? m0_writedata : '0;
        s_byteenable     = w_own1 ? m1_byteenable : w_own0 ? m0_byteenable : '0;
        s_read           = (w_own0 & m0_read & !w_blk0) | (w_own1 & m1_read & !w_blk1);
        s_write          = ((w_own0 & m0_write) | (w_own1 & m1_write)) & !s_read;
        m0_waitrequest   = !(w_own0 & !s_waitrequest & !w_blk0);
        m1_waitrequest   = !(w_own1 & !s_waitrequest & !w_blk1);
        m0_readdatavalid = s_readdatavalid & !w_empty & (w_head == M0);
        m1_readdatavalid = s_readdatavalid & !w_empty & (w_head == M1);
        m0_readdata      = s_readdata;
        m1_readdata      = s_readdata;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_proto_err <= 1'b0;
        else if (w_err) r_proto_err <= 1'b1;
    end

    arb_tag_fifo #(.MAX_PEND(MAX_PEND)) u_tag_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (w_push),
        .pop     (s_readdatavalid),
        .din     (w_owner),
        .head    (w_head),
        .count   (pend_cnt),
        .empty   (w_empty),
        .full    (w_full)
    );

endmodule

// File: tb/tb_sdram_rr_arbiter.sv
// tb_sdram_rr_arbiter: directed self-checking bench for the two-master SDRAM arbiter.
module tb_sdram_rr_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [24:0] m0_address, m1_address, s_address;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [15:0] m0_writedata, m1_writedata, s_writedata;
    logic [1:0]  m0_byteenable, m1_byteenable, s_byteenable;
    logic        m0_waitrequest, m1_waitrequest;
    logic [15:0] m0_readdata, m1_readdata, s_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic        s_read, s_write, s_waitrequest, s_readdatavalid;
    logic [2:0]  pend_cnt;
    logic        proto_err;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sdram_rr_arbiter #(.ADDR_W(25), .DATA_W(16), .MAX_PEND(4)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .m0_address       (m0_address),
        .m0_read          (m0_read),
        .m0_write         (m0_write),
        .m0_writedata     (m0_writedata),
        .m0_byteenable    (m0_byteenable),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdata      (m0_readdata),
        .m0_readdatavalid (m0_readdatavalid),
        .m1_address       (m1_address),
        .m1_read          (m1_read),
        .m1_write         (m1_write),
        .m1_writedata     (m1_writedata),
        .m1_byteenable    (m1_byteenable),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdata      (m1_readdata),
        .m1_readdatavalid (m1_readdatavalid),
        .s_address        (s_address),
        .s_read           (s_read),
        .s_write          (s_write),
        .s_writedata      (s_writedata),
        .s_byteenable     (s_byteenable),
        .s_waitrequest    (s_waitrequest),
        .s_readdata       (s_readdata),
        .s_readdatavalid  (s_readdatavalid),
        .pend_cnt         (pend_cnt),
        .proto_err        (proto_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        m0_address = '0; m0_read = 1'b0; m0_write = 1'b0; m0_writedata = '0; m0_byteenable = '0;
        m1_address = '0; m1_read = 1'b0; m1_write = 1'b0; m1_writedata = '0; m1_byteenable = '0;
        s_waitrequest = 1'b0; s_readdata = '0; s_readdatavalid = 1'b0;
    endtask

    initial begin
        clr();
        reset_n = 1'b0;
        #2;
        chk("rst_m0_wait", 32'(m0_waitrequest), 1);
        chk("rst_m1_wait", 32'(m1_waitrequest), 1);
        chk("rst_s_read", 32'(s_read), 0);
        chk("rst_s_write", 32'(s_write), 0);
        chk("rst_pend", 32'(pend_cnt), 0);
        chk("rst_err", 32'(proto_err), 0);
        cyc();
        reset_n = 1'b1;

        // Sole master write from IDLE: one cycle of grant latency
        cyc();
        m0_write = 1'b1; m0_address = 25'h10; m0_writedata = 16'hBEEF; m0_byteenable = 2'b11;
        #1;
        chk("wr_idle_wait", 32'(m0_waitrequest), 1);
        chk("wr_idle_s_write", 32'(s_write), 0);
        cyc();
        chk("wr_s_write", 32'(s_write), 1);
        chk("wr_s_addr", 32'(s_address), 'h10);
        chk("wr_s_data", 32'(s_writedata), 'hBEEF);
        chk("wr_s_be", 32'(s_byteenable), 3);
        chk("wr_m0_wait", 32'(m0_waitrequest), 0);
        cyc();
        m0_write = 1'b0;
        #1;
        chk("wr_done", 32'(s_write), 0);

        // Contention: both masters read 4 words, slave returns data one cycle later
        for (int i = 0; i < 10; i++) begin
            cyc();
            m0_read = (i <= 6); m0_address = 25'('h100 + (i + 1) / 2);
            m1_read = (i <= 7); m1_address = 25'('h200 + i / 2);
            s_readdatavalid = (i >= 1 && i <= 8); s_readdata = 16'(i);
            #1;
            if (i <= 7) begin
                chk("ct_s_read", 32'(s_read), 1);
                chk("ct_s_addr", 32'(s_address), ((i % 2) ? 'h200 : 'h100) + i / 2);
                chk("ct_m0_wait", 32'(m0_waitrequest), i % 2);
                chk("ct_m1_wait", 32'(m1_waitrequest), 1 - i % 2);
            end
            chk("ct_m0_rdv", 32'(m0_readdatavalid), (i >= 1 && i <= 8 && (i - 1) % 2 == 0) ? 1 : 0);
            chk("ct_m1_rdv", 32'(m1_readdatavalid), (i >= 1 && i <= 8 && (i - 1) % 2 == 1) ? 1 : 0);
            chk("ct_pend", 32'(pend_cnt), (i >= 1 && i <= 8) ? 1 : 0);
        end

        // Read return routing: m0 reads 0x300 then m1 reads 0x400
        cyc();
        clr();
        m0_read = 1'b1; m0_address = 25'h300;
        #1;
        chk("rt_m0_wait0", 32'(m0_waitrequest), 1);
        chk("rt_s_read0", 32'(s_read), 0);
        cyc();
        m1_read = 1'b1; m1_address = 25'h400;
        #1;
        chk("rt_s_addr_m0", 32'(s_address), 'h300);
        chk("rt_m0_wait1", 32'(m0_waitrequest), 0);
        chk("rt_m1_wait1", 32'(m1_waitrequest), 1);
        cyc();
        m0_read = 1'b0;
        #1;
        chk("rt_s_addr_m1", 32'(s_address), 'h400);
        chk("rt_m1_wait2", 32'(m1_waitrequest), 0);
        cyc();
        m1_read = 1'b0;
        #1;
        chk("rt_pend2", 32'(pend_cnt), 2);
        cyc();
        cyc();
        s_readdatavalid = 1'b1; s_readdata = 16'h1111;
        #1;
        chk("rt_1111_m0_rdv", 32'(m0_readdatavalid), 1);
        chk("rt_1111_m1_rdv", 32'(m1_readdatavalid), 0);
        chk("rt_1111_data", 32'(m0_readdata), 'h1111);
        cyc();
        s_readdata = 16'h2222;
        #1;
        chk("rt_2222_m0_rdv", 32'(m0_readdatavalid), 0);
        chk("rt_2222_m1_rdv", 32'(m1_readdatavalid), 1);
        chk("rt_2222_data", 32'(m1_readdata), 'h2222);
        cyc();
        s_readdatavalid = 1'b0;
        #1;
        chk("rt_pend0", 32'(pend_cnt), 0);

        // Stall hold: m1 owns with a write stalled 5 cycles while m0 waits to read
        for (int k = 0; k < 5; k++) begin
            cyc();
            m1_write = 1'b1; m1_address = 25'h600; m1_writedata = 16'hA5A5; m1_byteenable = 2'b11;
            m0_read = 1'b1; m0_address = 25'h700; s_waitrequest = 1'b1;
            #1;
            chk("st_s_write", 32'(s_write), 1);
            chk("st_s_addr", 32'(s_address), 'h600);
            chk("st_s_data", 32'(s_writedata), 'hA5A5);
            chk("st_s_read", 32'(s_read), 0);
            chk("st_m1_wait", 32'(m1_waitrequest), 1);
            chk("st_m0_wait", 32'(m0_waitrequest), 1);
        end
        cyc();
        s_waitrequest = 1'b0;
        #1;
        chk("st_acc_write", 32'(s_write), 1);
        chk("st_acc_m1_wait", 32'(m1_waitrequest), 0);
        cyc();
        m1_write = 1'b0;
        #1;
        chk("st_sw_s_read", 32'(s_read), 1);
        chk("st_sw_s_addr", 32'(s_address), 'h700);
        chk("st_sw_m0_wait", 32'(m0_waitrequest), 0);
        cyc();
        m0_read = 1'b0; s_readdatavalid = 1'b1; s_readdata = 16'h7777;
        #1;
        chk("st_m0_rdv", 32'(m0_readdatavalid), 1);
        chk("st_pend1", 32'(pend_cnt), 1);
        cyc();
        s_readdatavalid = 1'b0;
        #1;
        chk("st_pend0", 32'(pend_cnt), 0);

        // FIFO full: four reads outstanding, fifth held, owner's write still forwarded
        for (int i = 0; i < 4; i++) begin
            cyc();
            m0_read = 1'b1; m0_address = 25'('h500 + i);
            #1;
            chk("ff_s_read", 32'(s_read), 1);
            chk("ff_m0_wait", 32'(m0_waitrequest), 0);
            chk("ff_pend", 32'(pend_cnt), i);
        end
        cyc();
        m0_address = 25'h504; m0_write = 1'b1; m0_writedata = 16'h1234;
        #1;
        chk("ff_full_pend", 32'(pend_cnt), 4);
        chk("ff_full_s_read", 32'(s_read), 0);
        chk("ff_full_wait", 32'(m0_waitrequest), 1);
        chk("ff_full_s_write", 32'(s_write), 1);
        chk("ff_full_s_wdata", 32'(s_writedata), 'h1234);
        chk("ff_err_before", 32'(proto_err), 0);
        cyc();
        m0_write = 1'b0; s_readdatavalid = 1'b1; s_readdata = 16'hAAAA;
        #1;
        chk("ff_err_set", 32'(proto_err), 1);
        chk("ff_pop_s_read", 32'(s_read), 0);
        chk("ff_pop_s_write", 32'(s_write), 0);
        chk("ff_pop_m0_rdv", 32'(m0_readdatavalid), 1);
        cyc();
        s_readdatavalid = 1'b0;
        #1;
        chk("ff_rel_pend", 32'(pend_cnt), 3);
        chk("ff_rel_s_read", 32'(s_read), 1);
        chk("ff_rel_addr", 32'(s_address), 'h504);
        chk("ff_rel_wait", 32'(m0_waitrequest), 0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            m0_read = 1'b0; s_readdatavalid = 1'b1;
            #1;
            chk("ff_drain_pend", 32'(pend_cnt), 4 - i);
            chk("ff_drain_rdv", 32'(m0_readdatavalid), 1);
        end
        cyc();
        s_readdatavalid = 1'b0;
        #1;
        chk("ff_empty", 32'(pend_cnt), 0);
        chk("ff_err_sticky", 32'(proto_err), 1);

        // Reset clears the sticky error
        reset_n = 1'b0;
        #1;
        chk("rst2_err", 32'(proto_err), 0);
        cyc();
        reset_n = 1'b1;

        // Spurious readdatavalid with nothing pending
        cyc();
        s_readdatavalid = 1'b1; s_readdata = 16'hDEAD;
        #1;
        chk("sp_m0_rdv", 32'(m0_readdatavalid), 0);
        chk("sp_m1_rdv", 32'(m1_readdatavalid), 0);
        cyc();
        s_readdatavalid = 1'b0;
        #1;
        chk("sp_err", 32'(proto_err), 1);
        chk("sp_pend", 32'(pend_cnt), 0);

        // Asynchronous reset with two reads pending
        cyc();
        m0_read = 1'b1; m0_address = 25'h800;
        #1;
        chk("ar_idle_wait", 32'(m0_waitrequest), 1);
        cyc();
        #1;
        chk("ar_rd0", 32'(s_address), 'h800);
        cyc();
        m0_address = 25'h801;
        #1;
        chk("ar_rd1", 32'(s_read), 1);
        cyc();
        m0_read = 1'b0;
        #1;
        chk("ar_pend2", 32'(pend_cnt), 2);
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_pend", 32'(pend_cnt), 0);
        chk("ar_err", 32'(proto_err), 0);
        chk("ar_m0_wait", 32'(m0_waitrequest), 1);
        chk("ar_m1_wait", 32'(m1_waitrequest), 1);
        chk("ar_s_read", 32'(s_read), 0);
        cyc();
        reset_n = 1'b1;
        cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
